rca_seq_ctrl: RTL and testbench
===============================

Name: rca_seq_ctrl

Overview:
Sequencer that performs WIDTH-bit additions by time-multiplexing a single 4-bit ripple-carry slice over WIDTH/4 cycles, LSB nibble first.
- The slice carry is registered between cycles.
- It sits between a requester (valid/ready operand interface) and a consumer (valid/ready result interface).
- It is the team's area-lean alternative to a full-width adder.

Parameters:
WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; elaborate-time error otherwise.
SLICE, 4, slice width in bits. Fixed at 4 and not to be overridden.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  requester presents operands
in_ready  output  1  controller can accept operands (high only in IDLE)
a  input  WIDTH  operand A, sampled on accept
b  input  WIDTH  operand B, sampled on accept
c_in  input  1  carry-in to slice 0, sampled on accept
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result sum (registered)
c_out  output  1  carry out of the top slice (registered)
busy  output  1  high in RUN or DONE

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n sampled low at a clk rising edge resets all state. No asynchronous reset.
- Reset values:
  - state=IDLE, slice counter=0, carry reg=0, a/b regs=0.
  - sum=0, c_out=0, out_valid=0, busy=0, in_ready=1 from the first edge after reset.
- FSM has three states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, at that edge:
  - latch a, b; carry reg<=c_in; cnt<=0; clear sum reg; go to RUN.
- RUN: each cycle, the slice computes a[4*cnt+:4] + b[4*cnt+:4] + carry reg.
  - At the edge, the nibble is written to sum[4*cnt+:4] and carry reg<=slice carry.
  - If cnt==NSLICE-1: c_out<=slice carry, go to DONE. Otherwise cnt<=cnt+1.
  - NSLICE=WIDTH/4.
- DONE: out_valid=1 with sum/c_out stable. On out_ready, go to IDLE at that edge; out_valid drops the next cycle.
- Latency: out_valid rises exactly NSLICE cycles after the accept edge (WIDTH=16: 4 cycles).
- Throughput: at most one operation per NSLICE+2 cycles. No back-to-back accept in DONE, because in_ready=0 outside IDLE.
- in_valid while busy is ignored; the requester must hold it until in_ready.
- Inputs a, b and c_in may change freely after accept; only the latched copies are used.
- out_ready while not DONE is ignored. out_ready held high means a one-cycle DONE.
- Arithmetic is modulo 2^WIDTH; wrap-around is reported only via c_out.
- NSLICE=1 (WIDTH=4): RUN lasts one cycle.
- Reset mid-RUN or in DONE abandons the operation; all outputs return to reset values and no result is emitted.
- The counter is sized to the ceiling of log2(NSLICE), minimum 1 bit. It never exceeds NSLICE-1.

Optional Feature:
Macro SUB_EN.
- Defined: adds input port `sub` (1 bit), sampled on accept.
  - sub=1: computes a - b as a + ~b + 1. b is inverted at latch, and the carry reg is loaded with 1 (c_in ignored).
  - c_out=1 means no borrow.
  - sub=0 behaves exactly as without the macro.
- Undefined: no `sub` port; add-only.

Decomposition:
- Package rca_pkg holds:
  - localparam SLICE_W=4;
  - the state enum/encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - a function computing NSLICE and counter width.
- One sub-module, rca_slice4: purely combinational 4-bit ripple adder built from full adders, with ports a[3:0], b[3:0], ci, s[3:0], co. It is instantiated once.

Test Plan:
1. Reset, then hold rst_n=1 with no traffic -> in_ready=1, out_valid=0, busy=0, sum=0, c_out=0 indefinitely.
2. WIDTH=16: a=16'hFFFE, b=16'h0001, c_in=0 -> out_valid 4 cycles after accept; sum=16'hFFFF, c_out=0.
3. a=16'hFFFF, b=16'h0001, c_in=0 -> sum=16'h0000, c_out=1; checks carry ripple across all slice boundaries.
4. a=16'h1234, b=16'h0FCB, c_in=1, out_ready held low 5 cycles -> out_valid stays 1, sum=16'h2200 stable; in_ready=0 and a new in_valid is ignored until the handshake.
5. Assert rst_n=0 for one edge at RUN cnt=2, then issue a=16'h0008, b=16'h0008 -> no stale result; sum=16'h0010, c_out=0.
6. SUB_EN: sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, c_out=0. Then sub=1, a=16'h0007, b=16'h0005 -> sum=16'h0002, c_out=1.

Source files
------------

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared slice width, FSM encoding and sizing helpers for rca_seq_ctrl
package rca_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int calc_nslice(input int width);
        return width / SLICE_W;
    endfunction

    // A single-slice build still needs a 1-bit counter to keep the select logic well formed.
    function automatic int calc_cnt_w(input int nslice);
        return (nslice <= 1) ? 1 : $clog2(nslice);
    endfunction

endpackage

// File: rtl/rca_slice4.sv
// rtl/rca_slice4.sv - combinational 4-bit ripple-carry adder built from full adders
module rca_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign co = w_c[4];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - nibble-serial WIDTH-bit adder sequencer; SUB_EN adds a subtract mode
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int NSLICE = calc_nslice(WIDTH);
    localparam int CNT_W  = calc_cnt_w(NSLICE);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
    if (SLICE != SLICE_W) begin : g_bad_slice
        $error("rca_seq_ctrl: SLICE is fixed at 4");
    end

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic [SLICE_W-1:0] w_a_nib;
    logic [SLICE_W-1:0] w_b_nib;
    logic [SLICE_W-1:0] w_s_nib;
    logic               w_co;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_cnt == LAST);
    assign w_a_nib  = r_a[{r_cnt, 2'b00} +: SLICE_W];
    assign w_b_nib  = r_b[{r_cnt, 2'b00} +: SLICE_W];

    rca_slice4 u_slice (
        .a  (w_a_nib),
        .b  (w_b_nib),
        .ci (r_carry),
        .s  (w_s_nib),
        .co (w_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a   <= a;
                        r_cnt <= '0;
                        r_sum <= '0;
`ifdef SUB_EN
                        // a - b == a + ~b + 1, so invert once here and seed the carry.
                        r_b     <= sub ? ~b : b;
                        r_carry <= sub ? 1'b1 : c_in;
`else
                        r_b     <= b;
                        r_carry <= c_in;
`endif
                    end
                end
                ST_RUN: begin
                    r_sum[{r_cnt, 2'b00} +: SLICE_W] <= w_s_nib;
                    r_carry <= w_co;
                    if (w_last) begin
                        r_cout <= w_co;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum   = r_sum;
    assign c_out = r_cout;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// tb/tb_rca_seq_ctrl.sv - scoreboard bench for rca_seq_ctrl (WIDTH=16, SUB_EN cases when defined)
module tb_rca_seq_ctrl;

    localparam int WIDTH  = 16;
    localparam int NSLICE = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             busy;

    int errors = 0;
    int checks = 0;
    logic [WIDTH:0] exp_q[$];

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                                             input logic cin, input logic sb);
        logic [WIDTH:0] r;
        if (sb) r = {1'b0, oa} + {1'b0, ~ob} + (WIDTH+1)'(1);
        else    r = {1'b0, oa} + {1'b0, ob} + {{WIDTH{1'b0}}, cin};
        return r;
    endfunction

    task automatic check_idle(input string tag);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready: got %b expected 1", tag, in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s out_valid: got %b expected 0", tag, out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy: got %b expected 0", tag, busy); end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic cin,
                         input logic sb, input int hold, input bit inject);
        int cyc;
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] held;
        @(negedge clk);
        in_valid = 1'b1; a = oa; b = ob; c_in = cin; sub = sb;
        cyc = 0;
        while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL accept_timeout: got in_ready=%b expected 1", in_ready);
            in_valid = 1'b0; return;
        end
        @(posedge clk);
        exp_q.push_back(model(oa, ob, cin, sb));
        @(negedge clk);
        in_valid = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 50) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc != NSLICE) begin errors++; $display("FAIL latency: got %0d expected %0d", cyc, NSLICE); end
        if (!out_valid) return;
        held = sum;
        for (int i = 0; i < hold; i++) begin
            if (inject) begin in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); end
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid: got %b expected 1", out_valid); end
            checks++; if (sum !== held) begin errors++; $display("FAIL hold_sum: got %h expected %h", sum, held); end
            checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL hold_ready_busy: got %b%b expected 01", in_ready, busy);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            exp = exp_q.pop_front();
            checks++; if (sum !== exp[WIDTH-1:0]) begin errors++; $display("FAIL sum: got %h expected %h", sum, exp[WIDTH-1:0]); end
            checks++; if (c_out !== exp[WIDTH]) begin errors++; $display("FAIL c_out: got %b expected %b", c_out, exp[WIDTH]); end
        end
        @(negedge clk);
        out_ready = 1'b0;
        check_idle("post_handshake");
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_idle("reset_idle");
            checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
            checks++; if (c_out !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", c_out); end
        end
    endtask

    task automatic test_carry_ripple();
        do_op(16'hFFFE, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op(16'h1234, 16'h0FCB, 1'b1, 1'b0, 5, 1'b1);
        repeat (2) begin
            @(negedge clk);
            check_idle("after_inject");
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; c_in = 1'b1; sub = 1'b0;
        @(posedge clk);
        exp_q.push_back(model(16'hABCD, 16'h1111, 1'b1, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        for (int i = 0; i < 6; i++) begin
            check_idle("abandon");
            checks++; if (sum !== '0 || c_out !== 1'b0) begin
                errors++; $display("FAIL abandon_result: got %h/%b expected 0000/0", sum, c_out);
            end
            @(negedge clk);
        end
        do_op(16'h0008, 16'h0008, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, int'($urandom_range(0, 2)), 1'b1);
        end
    endtask

`ifdef SUB_EN
    task automatic test_sub();
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_carry_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_random();
`ifdef SUB_EN
        test_sub();
`endif
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
